rr_arb_4req_dec: RTL and testbench

//  4-requester round-robin arbiter for a shared resource selected through a 2-to-4 decoder.
//  - Chooses one requester at a time and drives a 2-bit grant index.
//  - Drives the one-hot grant that the 2-to-4 decoder produces from that index.
//  - Limits the hold time per grant and keeps a one-cycle dead gap between grants.
//  - Sits between the requesters and the decoder-selected resource.

---
 rtl/rr_arb_4req_dec.sv | 98 +++++++++
 tb/tb_rr_arb_4req_dec.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_4req_dec.sv
// rr_arb_4req_dec: 4-way round-robin arbiter driving a 2-bit grant index
// and its 2-to-4 decoded one-hot grant, with hold limit and one-cycle gap.
module rr_arb_4req_dec #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arb_en,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [1:0]        state;
   logic [1:0]        last;
   logic [HOLD_W-1:0] hold_cnt;

   logic [1:0] win;
   logic       hit;
   logic [1:0] probe;
   logic [3:0] win_dec;

   // Scan from the requester after the last winner; i=4 wraps back to last.
   always_comb begin
      win   = last;
      hit   = 1'b0;
      probe = '0;
      for (int i = 1; i <= 4; i++) begin
         probe = last + 2'(i);
         if (!hit && req[probe]) begin
            win = probe;
            hit = 1'b1;
         end
      end
   end

   always_comb begin
      win_dec = 4'b0000;
      unique case (1'b1)
         (win == 2'd0): win_dec = 4'b0001;
         (win == 2'd1): win_dec = 4'b0010;
         (win == 2'd2): win_dec = 4'b0100;
         (win == 2'd3): win_dec = 4'b1000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         last      <= 2'd3;
         hold_cnt  <= '0;
         gnt       <= 4'b0000;
         gnt_idx   <= 2'd0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         unique case (state)
            S_GRANT: begin
               if (!req[gnt_idx]) begin
                  state     <= S_GAP;
                  gnt       <= 4'b0000;
                  gnt_valid <= 1'b0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state     <= S_GAP;
                  gnt       <= 4'b0000;
                  gnt_valid <= 1'b0;
                  timeout   <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               if (arb_en && hit) begin
                  state     <= S_GRANT;
                  gnt_idx   <= win;
                  last      <= win;
                  gnt       <= win_dec;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
               end else begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb_4req_dec.sv
// tb_rr_arb_4req_dec: directed checks of grant order, hold limit, gap,
// arb_en gating and asynchronous reset for rr_arb_4req_dec.
module tb_rr_arb_4req_dec;

   logic       clk;
   logic       rst_n;
   logic       arb_en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int n_chk;
   int n_fail;

   rr_arb_4req_dec #(.MAX_HOLD(8), .HOLD_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arb_en    (arb_en),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gnt(input string tag, input logic [3:0] g,
                          input logic [1:0] idx, input logic v,
                          input logic to);
      check({tag, ".gnt"}, 8'(gnt), 8'(g));
      check({tag, ".idx"}, 8'(gnt_idx), 8'(idx));
      check({tag, ".valid"}, 8'(gnt_valid), 8'(v));
      check({tag, ".timeout"}, 8'(timeout), 8'(to));
   endtask

   // Structural invariants sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         check("inv.onehot", 8'($countones(gnt) <= 1), 8'd1);
         check("inv.valid", 8'(gnt != 4'b0000), 8'(gnt_valid));
         if (timeout)
            check("inv.to_valid", 8'(gnt_valid), 8'd0);
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      arb_en = 1'b1;
      req    = 4'b1111;

      // Reset state
      #12;
      chk_gnt("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_gnt("rst_clk", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_gnt("rst_first", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      chk_gnt("rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();

      // Single requester with one-cycle overlap on release
      req = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         step();
         chk_gnt("single", 4'b0100, 2'd2, 1'b1, 1'b0);
      end
      req = 4'b0000;
      step();
      chk_gnt("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
      step();
      chk_gnt("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

      // Saturation after a fresh reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 8; c++) begin
            step();
            chk_gnt("sat", 4'(1 << k), 2'(k), 1'b1, 1'b0);
         end
         step();
         chk_gnt("sat_gap", 4'b0000, 2'(k), 1'b0, 1'b1);
      end
      step();
      chk_gnt("sat_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      chk_gnt("sat_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();

      // Rotation
      req = 4'b0010;
      step();
      chk_gnt("rot_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b1011;
      step();
      chk_gnt("rot_hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b1001;
      step();
      chk_gnt("rot_gap1", 4'b0000, 2'd1, 1'b0, 1'b0);
      step();
      chk_gnt("rot_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = 4'b0011;
      step();
      chk_gnt("rot_gap3", 4'b0000, 2'd3, 1'b0, 1'b0);
      step();
      chk_gnt("rot_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b0010;
      step();
      chk_gnt("rot_gap0", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_gnt("rot_g1b", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      step();

      // arb_en gating
      arb_en = 1'b0;
      req = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         step();
         chk_gnt("en_off", 4'b0000, 2'd1, 1'b0, 1'b0);
      end
      arb_en = 1'b1;
      step();
      chk_gnt("en_on", 4'b0010, 2'd1, 1'b1, 1'b0);
      arb_en = 1'b0;
      for (int c = 0; c < 7; c++) begin
         step();
         chk_gnt("en_mid", 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      step();
      chk_gnt("en_to", 4'b0000, 2'd1, 1'b0, 1'b1);
      step();
      chk_gnt("en_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

      // Asynchronous reset mid-grant
      arb_en = 1'b1;
      req = 4'b0100;
      step();
      chk_gnt("ar_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_gnt("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      req = 4'b1111;
      step();
      chk_gnt("ar_restart", 4'b0001, 2'd0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
